// File: rtl/regfile_wr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_wr_arbiter_if
//  Purpose  : Bundles the two requester channels and the registered write
//             port of the register-bank write arbiter.
//  Ports    : req0/1, addr0/1, data0/1, lock0/1  requester side
//             gnt0/1                              combinational accepts
//             we_o, wdata_o                       registered bank write port
//             owner_o                             current lock owner
//  Revision : 1.0  initial release
// ============================================================================
interface regfile_wr_arbiter_if #(
   parameter int NREG = 8,
   parameter int AW   = 3,
   parameter int DW   = 16
);
   logic            req0;
   logic            req1;
   logic [AW-1:0]   addr0;
   logic [AW-1:0]   addr1;
   logic [DW-1:0]   data0;
   logic [DW-1:0]   data1;
   logic            lock0;
   logic            lock1;
   logic            gnt0;
   logic            gnt1;
   logic [NREG-1:0] we_o;
   logic [DW-1:0]   wdata_o;
   logic [1:0]      owner_o;

   // Requesters and bank side
   modport master (
      output req0, req1, addr0, addr1, data0, data1, lock0, lock1,
      input  gnt0, gnt1, we_o, wdata_o, owner_o
   );

   // Arbiter side
   modport slave (
      input  req0, req1, addr0, addr1, data0, data1, lock0, lock1,
      output gnt0, gnt1, we_o, wdata_o, owner_o
   );
endinterface
`default_nettype wire

// File: rtl/regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_wr_arbiter
//  Purpose  : Shares the single register-bank write port between core
//             write-back (requester 0) and the load/debug port (requester 1).
//             Round-robin on ties, optional locked bursts with an idle
//             timeout, registered one-hot write enable and write data.
//  Ports    : clk      clock, rising edge
//             rst      asynchronous active-high reset
//             bus      regfile_wr_arbiter_if.slave (requests, grants,
//                      we_o / wdata_o / owner_o)
//  Revision : 1.0  initial release
// ============================================================================
module regfile_wr_arbiter #(
   parameter int NREG     = 8,
   parameter int AW       = 3,
   parameter int DW       = 16,
   parameter int R0_ZERO  = 1,
   parameter int MAX_LOCK = 15
) (
   input wire clk,
   input wire rst,
   regfile_wr_arbiter_if.slave bus
);

   // Encoding chosen so the state drives owner_o directly.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_OWN0 = 2'b01,
      ST_OWN1 = 2'b10
   } state_t;

   localparam logic [7:0] C_MAX_LOCK = 8'(MAX_LOCK);

   state_t          state_q, state_d;
   logic            rr_last_q, rr_last_d;
   logic [7:0]      idle_cnt_q, idle_cnt_d;
   logic [NREG-1:0] we_q, we_d;
   logic [DW-1:0]   wdata_q, wdata_d;

   logic            gnt0;
   logic            gnt1;
   logic [AW-1:0]   sel_addr;
   logic [DW-1:0]   sel_data;
   logic            sel_lock;
   logic [7:0]      idle_inc;

   assign idle_inc = idle_cnt_q + 8'd1;

   always_comb begin
      state_d    = state_q;
      rr_last_d  = rr_last_q;
      idle_cnt_d = idle_cnt_q;
      we_d       = '0;
      wdata_d    = wdata_q;
      gnt0       = 1'b0;
      gnt1       = 1'b0;

      // Grants look only at req, state and rr_last, never at addr/data.
      case (state_q)
         ST_IDLE: begin
            // rr_last=1 means requester 1 won last, so 0 takes the tie.
            if (bus.req0 && (!bus.req1 || rr_last_q)) begin
               gnt0 = 1'b1;
            end else if (bus.req1) begin
               gnt1 = 1'b1;
            end
         end
         ST_OWN0: gnt0 = bus.req0;
         ST_OWN1: gnt1 = bus.req1;
         default: begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
         end
      endcase

      sel_addr = gnt1 ? bus.addr1 : bus.addr0;
      sel_data = gnt1 ? bus.data1 : bus.data0;
      sel_lock = gnt1 ? bus.lock1 : bus.lock0;

      if (gnt0 || gnt1) begin
         rr_last_d  = gnt1;
         idle_cnt_d = '0;
         wdata_d    = sel_data;
         // R0 stays hardwired to zero: grant completes, enable is dropped.
         if (!((R0_ZERO != 0) && (sel_addr == '0))) begin
            we_d[sel_addr] = 1'b1;
         end
         if (sel_lock) begin
            state_d = gnt1 ? ST_OWN1 : ST_OWN0;
         end else begin
            state_d = ST_IDLE;
         end
      end else if (state_q != ST_IDLE) begin
         // Owner idle: force release on the cycle the count reaches the limit.
         if (idle_inc >= C_MAX_LOCK) begin
            state_d    = ST_IDLE;
            idle_cnt_d = '0;
         end else begin
            idle_cnt_d = idle_inc;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         rr_last_q  <= 1'b1;
         idle_cnt_q <= '0;
         we_q       <= '0;
         wdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         rr_last_q  <= rr_last_d;
         idle_cnt_q <= idle_cnt_d;
         we_q       <= we_d;
         wdata_q    <= wdata_d;
      end
   end

   assign bus.gnt0    = gnt0;
   assign bus.gnt1    = gnt1;
   assign bus.we_o    = we_q;
   assign bus.wdata_o = wdata_q;
   assign bus.owner_o = state_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wr_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_regfile_wr_arbiter
//  Purpose  : Self-checking bench for regfile_wr_arbiter: directed vector
//             table, lock-timeout and reset sequences, random traffic against
//             a behavioural reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_regfile_wr_arbiter;
   localparam int NREG     = 8;
   localparam int AW       = 3;
   localparam int DW       = 16;
   localparam int R0_ZERO  = 1;
   localparam int MAX_LOCK = 15;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   regfile_wr_arbiter_if #(.NREG(NREG), .AW(AW), .DW(DW)) bus ();

   regfile_wr_arbiter #(
      .NREG(NREG), .AW(AW), .DW(DW), .R0_ZERO(R0_ZERO), .MAX_LOCK(MAX_LOCK)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int errors = 0;
   int checks = 0;

   // Reference model: owner 0=none,1=req0,2=req1; last = last winner index.
   int              m_owner;
   int              m_last;
   int              m_idle;
   int              m_win;
   logic [NREG-1:0] m_we;
   logic [DW-1:0]   m_wdata;

   typedef struct {
      logic            r0;
      logic [AW-1:0]   a0;
      logic [DW-1:0]   d0;
      logic            l0;
      logic            r1;
      logic [AW-1:0]   a1;
      logic [DW-1:0]   d1;
      logic            l1;
      logic            eg0;
      logic            eg1;
      logic [NREG-1:0] ewe;
      logic [DW-1:0]   ewd;
      logic [1:0]      eown;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(input logic r0, input logic [AW-1:0] a0,
                               input logic [DW-1:0] d0, input logic l0,
                               input logic r1, input logic [AW-1:0] a1,
                               input logic [DW-1:0] d1, input logic l1,
                               input logic eg0, input logic eg1,
                               input logic [NREG-1:0] ewe,
                               input logic [DW-1:0] ewd,
                               input logic [1:0] eown);
      vec_t v;
      v.r0 = r0; v.a0 = a0; v.d0 = d0; v.l0 = l0;
      v.r1 = r1; v.a1 = a1; v.d1 = d1; v.l1 = l1;
      v.eg0 = eg0; v.eg1 = eg1; v.ewe = ewe; v.ewd = ewd; v.eown = eown;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic set_in(input logic r0, input logic [AW-1:0] a0,
                         input logic [DW-1:0] d0, input logic l0,
                         input logic r1, input logic [AW-1:0] a1,
                         input logic [DW-1:0] d1, input logic l1);
      bus.req0 = r0; bus.addr0 = a0; bus.data0 = d0; bus.lock0 = l0;
      bus.req1 = r1; bus.addr1 = a1; bus.data1 = d1; bus.lock1 = l1;
   endtask

   task automatic model_reset();
      m_owner = 0; m_last = 1; m_idle = 0; m_win = -1;
      m_we = '0; m_wdata = '0;
   endtask

   // Who may write this cycle, from ownership and round-robin history.
   task automatic model_pick();
      m_win = -1;
      if (m_owner == 0) begin
         if (bus.req0 && bus.req1) m_win = 1 - m_last;
         else if (bus.req0)        m_win = 0;
         else if (bus.req1)        m_win = 1;
      end else if (m_owner == 1) begin
         if (bus.req0) m_win = 0;
      end else begin
         if (bus.req1) m_win = 1;
      end
   endtask

   // Effect of the coming clock edge on the model.
   task automatic model_commit();
      int a;
      logic l;
      logic [DW-1:0] d;
      if (m_win >= 0) begin
         a = (m_win == 0) ? int'(bus.addr0) : int'(bus.addr1);
         d = (m_win == 0) ? bus.data0 : bus.data1;
         l = (m_win == 0) ? bus.lock0 : bus.lock1;
         m_we = '0;
         if (!(R0_ZERO != 0 && a == 0)) m_we[a] = 1'b1;
         m_wdata = d;
         m_last  = m_win;
         m_idle  = 0;
         m_owner = l ? m_win + 1 : 0;
      end else begin
         m_we = '0;
         if (m_owner != 0) begin
            m_idle++;
            if (m_idle >= MAX_LOCK) begin
               m_owner = 0;
               m_idle  = 0;
            end
         end
      end
   endtask

   task automatic tick();
      model_commit();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_we",    32'(bus.we_o),    32'h0);
      chk("rst_wdata", 32'(bus.wdata_o), 32'h0);
      chk("rst_owner", 32'(bus.owner_o), 32'h0);
      chk("rst_gnt0",  32'(bus.gnt0),    32'h0);
      chk("rst_gnt1",  32'(bus.gnt1),    32'h0);
      rst = 1'b0;

      // ---- directed table: expected values seen in each cycle ----
      // alternating round-robin, a0=1 a1=6
      vq.push_back(mk(1,1,16'h1111,0, 1,6,16'h6666,0, 1,0, 8'h00,16'h0000,2'b00));
      vq.push_back(mk(1,1,16'h1111,0, 1,6,16'h6666,0, 0,1, 8'h02,16'h1111,2'b00));
      vq.push_back(mk(1,1,16'h1111,0, 1,6,16'h6666,0, 1,0, 8'h40,16'h6666,2'b00));
      vq.push_back(mk(1,1,16'h1111,0, 1,6,16'h6666,0, 0,1, 8'h02,16'h1111,2'b00));
      vq.push_back(mk(0,0,16'h0000,0, 0,0,16'h0000,0, 0,0, 8'h40,16'h6666,2'b00));
      // single write to r3
      vq.push_back(mk(1,3,16'hA5A5,0, 0,0,16'h0000,0, 1,0, 8'h00,16'h6666,2'b00));
      vq.push_back(mk(0,0,16'h0000,0, 0,0,16'h0000,0, 0,0, 8'h08,16'hA5A5,2'b00));
      vq.push_back(mk(0,0,16'h0000,0, 0,0,16'h0000,0, 0,0, 8'h00,16'hA5A5,2'b00));
      // requester 1 locked burst 2,4,5 while req0 waits on r7
      vq.push_back(mk(1,7,16'h7777,0, 1,2,16'h2222,1, 0,1, 8'h00,16'hA5A5,2'b00));
      vq.push_back(mk(1,7,16'h7777,0, 1,4,16'h4444,1, 0,1, 8'h04,16'h2222,2'b10));
      vq.push_back(mk(1,7,16'h7777,0, 1,5,16'h5555,0, 0,1, 8'h10,16'h4444,2'b10));
      vq.push_back(mk(1,7,16'h7777,0, 0,0,16'h0000,0, 1,0, 8'h20,16'h5555,2'b00));
      vq.push_back(mk(0,0,16'h0000,0, 0,0,16'h0000,0, 0,0, 8'h80,16'h7777,2'b00));
      // write to R0 is suppressed but data still loads
      vq.push_back(mk(1,0,16'hFFFF,0, 0,0,16'h0000,0, 1,0, 8'h00,16'h7777,2'b00));
      vq.push_back(mk(0,0,16'h0000,0, 0,0,16'h0000,0, 0,0, 8'h00,16'hFFFF,2'b00));
      vq.push_back(mk(0,0,16'h0000,0, 0,0,16'h0000,0, 0,0, 8'h00,16'hFFFF,2'b00));
      // requester 0 lock blocks requester 1 the next cycle
      vq.push_back(mk(1,1,16'h1212,1, 0,0,16'h0000,0, 1,0, 8'h00,16'hFFFF,2'b00));
      vq.push_back(mk(1,2,16'h2323,0, 1,3,16'h3333,0, 1,0, 8'h02,16'h1212,2'b01));
      vq.push_back(mk(0,0,16'h0000,0, 1,3,16'h3333,0, 0,1, 8'h04,16'h2323,2'b00));
      vq.push_back(mk(0,0,16'h0000,0, 0,0,16'h0000,0, 0,0, 8'h08,16'h3333,2'b00));

      foreach (vq[i]) begin
         set_in(vq[i].r0, vq[i].a0, vq[i].d0, vq[i].l0,
                vq[i].r1, vq[i].a1, vq[i].d1, vq[i].l1);
         #3;
         model_pick();
         chk($sformatf("vec%0d_gnt0", i),  32'(bus.gnt0),    32'(vq[i].eg0));
         chk($sformatf("vec%0d_gnt1", i),  32'(bus.gnt1),    32'(vq[i].eg1));
         chk($sformatf("vec%0d_we", i),    32'(bus.we_o),    32'(vq[i].ewe));
         chk($sformatf("vec%0d_wdata", i), 32'(bus.wdata_o), 32'(vq[i].ewd));
         chk($sformatf("vec%0d_owner", i), 32'(bus.owner_o), 32'(vq[i].eown));
         tick();
      end

      // ---- lock timeout: owner 0 idles while requester 1 waits ----
      set_in(1, 4, 16'h4444, 1, 0, 0, 0, 0);
      #3;
      model_pick();
      chk("to_grant0", 32'(bus.gnt0), 32'h1);
      tick();
      for (int k = 1; k <= MAX_LOCK; k++) begin
         set_in(0, 0, 0, 0, 1, 6, 16'h6060, 0);
         #3;
         model_pick();
         chk($sformatf("to_idle%0d_gnt1", k),  32'(bus.gnt1),    32'h0);
         chk($sformatf("to_idle%0d_owner", k), 32'(bus.owner_o), 32'h1);
         tick();
      end
      #3;
      model_pick();
      chk("to_release_owner", 32'(bus.owner_o), 32'h0);
      chk("to_release_gnt1",  32'(bus.gnt1),    32'h1);
      chk("to_release_we",    32'(bus.we_o),    32'h0);
      tick();
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      chk("to_after_we",    32'(bus.we_o),    32'h40);
      chk("to_after_wdata", 32'(bus.wdata_o), 32'h6060);

      // ---- reset in the cycle after a locked grant ----
      set_in(1, 5, 16'h5A5A, 1, 0, 0, 0, 0);
      #3;
      model_pick();
      chk("rs_grant0", 32'(bus.gnt0), 32'h1);
      tick();
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      chk("rs_pre_owner", 32'(bus.owner_o), 32'h1);
      rst = 1'b1;
      #1;
      model_reset();
      chk("rs_we_cleared",    32'(bus.we_o),    32'h0);
      chk("rs_owner_cleared", 32'(bus.owner_o), 32'h0);
      @(posedge clk);
      #1;
      chk("rs_we_held", 32'(bus.we_o), 32'h0);
      rst = 1'b0;
      set_in(1, 1, 16'hAAAA, 0, 1, 2, 16'hBBBB, 0);
      #3;
      model_pick();
      chk("rs_tie_gnt0", 32'(bus.gnt0), 32'h1);
      chk("rs_tie_gnt1", 32'(bus.gnt1), 32'h0);
      tick();
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      chk("rs_tie_we", 32'(bus.we_o), 32'h02);
      #3;
      model_pick();
      tick();

      // ---- random traffic against the reference model ----
      for (int n = 0; n < 400; n++) begin
         set_in($urandom_range(0, 3) != 0, AW'($urandom), DW'($urandom),
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 2) != 0, AW'($urandom), DW'($urandom),
                $urandom_range(0, 3) == 0);
         #3;
         model_pick();
         chk("rnd_gnt0",  32'(bus.gnt0),    32'(m_win == 0));
         chk("rnd_gnt1",  32'(bus.gnt1),    32'(m_win == 1));
         chk("rnd_we",    32'(bus.we_o),    32'(m_we));
         chk("rnd_wdata", 32'(bus.wdata_o), 32'(m_wdata));
         chk("rnd_owner", 32'(bus.owner_o), 32'(m_owner));
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
